// File: rtl/fp_acc.sv
// fp_acc: multi-cycle FP32 accumulator. Each accepted product is added to the
// running sum through ALIGN/ADD/NORM/RND (one beat per 5 cycles). The beat
// flagged in_last closes the sum, which is then held in OUT until it is taken.
module fp_acc #(
  parameter int unsigned BIT_W = 32,
  parameter int unsigned EXP_W = 8,
  parameter int unsigned M_W   = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIT_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIT_W-1:0] out_data,
  output logic [15:0]      out_count
);

  localparam int unsigned MAN_W = M_W + 1;           // mantissa with hidden bit
  localparam int unsigned EXT_W = MAN_W + 3;         // plus guard, round, sticky
  localparam int unsigned SUM_W = EXT_W + 1;         // plus carry
  localparam int unsigned EW    = EXP_W + 2;         // exponent with headroom
  localparam int unsigned LZ_W  = $clog2(EXT_W + 1);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [BIT_W-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(M_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_RND, S_OUT
  } state_e;

  state_e             state_q, state_d;
  logic               accept;
  logic [BIT_W-1:0]   acc_q, acc_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]   beat_q;
  logic               last_q;
  logic               in_ready_q;
  logic               out_valid_q;

  // Pipeline registers, each loaded in its own stage
  logic               sign_q, sign_d;
  logic [EW-1:0]      exp_q, exp_d;
  logic [EXT_W-1:0]   big_q, big_d;
  logic [EXT_W-1:0]   small_q, small_d;
  logic               sub_q, sub_d;
  logic               spec_q, spec_d;
  logic [BIT_W-1:0]   spec_res_q, spec_res_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [EXT_W-1:0]   norm_q, norm_d;
  logic [EW-1:0]      nexp_q, nexp_d;
  logic               zero_q, zero_d;

  // Operand decode: a = accumulator, b = accepted beat
  logic               a_s, b_s;
  logic [EXP_W-1:0]   a_e, b_e;
  logic [M_W-1:0]     a_m, b_m;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
  logic [BIT_W-2:0]   a_key, b_key;
  logic [MAN_W-1:0]   a_man, b_man;
  logic [EXP_W-1:0]   big_e, sml_e, sh;
  logic [MAN_W-1:0]   big_man, sml_man;
  logic [EXT_W-1:0]   sml_ext, sml_mask;

  logic [LZ_W-1:0]    lz;
  logic [MAN_W-1:0]   r_man;
  logic               r_up;
  logic [MAN_W:0]     r_sum;
  logic [EW-1:0]      r_exp;
  logic [M_W-1:0]     r_frac;
  logic [BIT_W-1:0]   rnd_res;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign out_count = cnt_q;

  // Next-state logic: fixed one-state-per-cycle walk through the datapath
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_RND;
      S_RND:   state_d = last_q ? S_OUT : S_IDLE;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulator and beat counter updates
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (accept) cnt_d = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
    if (state_q == S_RND) acc_d = rnd_res;
    if (state_q == S_OUT && out_ready) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  // Control state, accumulator and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      beat_q      <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_OUT);
      if (accept) begin
        beat_q <= in_data;
        last_q <= in_last;
      end
    end
  end

  assign a_s    = acc_q[BIT_W-1];
  assign a_e    = acc_q[BIT_W-2 -: EXP_W];
  assign a_m    = acc_q[M_W-1:0];
  assign b_s    = beat_q[BIT_W-1];
  assign b_e    = beat_q[BIT_W-2 -: EXP_W];
  assign b_m    = beat_q[M_W-1:0];
  assign a_zero = (a_e == '0);
  assign b_zero = (b_e == '0);
  assign a_inf  = (a_e == EXP_MAX) && (a_m == '0);
  assign b_inf  = (b_e == EXP_MAX) && (b_m == '0);
  assign a_nan  = (a_e == EXP_MAX) && (a_m != '0);
  assign b_nan  = (b_e == EXP_MAX) && (b_m != '0);
  // Subnormals compare and align as zero
  assign a_key  = a_zero ? '0 : acc_q[BIT_W-2:0];
  assign b_key  = b_zero ? '0 : beat_q[BIT_W-2:0];
  assign a_man  = a_zero ? '0 : {1'b1, a_m};
  assign b_man  = b_zero ? '0 : {1'b1, b_m};
  assign a_big  = (a_key >= b_key);

  // ALIGN: special-case detection and right shift of the smaller operand
  always_comb begin
    spec_d     = 1'b0;
    spec_res_d = '0;
    big_e      = a_big ? a_e : b_e;
    sml_e      = a_big ? b_e : a_e;
    big_man    = a_big ? a_man : b_man;
    sml_man    = a_big ? b_man : a_man;
    sh         = big_e - sml_e;
    sml_ext    = {sml_man, 3'b000};
    sml_mask   = ~({EXT_W{1'b1}} << sh);
    sign_d     = a_big ? a_s : b_s;
    sub_d      = a_s ^ b_s;
    exp_d      = EW'(big_e);
    big_d      = {big_man, 3'b000};
    small_d    = (sml_ext >> sh) | {{(EXT_W-1){1'b0}}, |(sml_ext & sml_mask)};
    if (sh >= EXP_W'(EXT_W - 1)) small_d = {{(EXT_W-1){1'b0}}, |sml_man};

    if (a_nan || b_nan) begin
      spec_d     = 1'b1;
      spec_res_d = QNAN;
    end else if (a_inf && b_inf) begin
      spec_d     = 1'b1;
      spec_res_d = (a_s == b_s) ? acc_q : QNAN;
    end else if (a_inf) begin
      spec_d     = 1'b1;
      spec_res_d = acc_q;
    end else if (b_inf) begin
      spec_d     = 1'b1;
      spec_res_d = beat_q;
    end else if (a_zero && b_zero) begin
      spec_d     = 1'b1;
      spec_res_d = {a_s & b_s, {(BIT_W-1){1'b0}}};
    end
  end

  // ADD: magnitude add or subtract; big_q >= small_q by construction
  assign sum_d = sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                       : ({1'b0, big_q} + {1'b0, small_q});

  // NORM: carry right-shift or leading-zero left-shift, flush underflow to +0
  always_comb begin
    lz     = '0;
    norm_d = sum_q[EXT_W-1:0];
    nexp_d = exp_q;
    zero_d = 1'b0;
    for (int i = 0; i < EXT_W; i++) begin
      if (sum_q[i]) lz = LZ_W'(EXT_W - 1 - i);
    end
    if (sum_q[SUM_W-1]) begin
      norm_d = {sum_q[SUM_W-1:2], |sum_q[1:0]};
      nexp_d = exp_q + EW'(1);
    end else if (sum_q == '0) begin
      zero_d = 1'b1;
    end else if (EW'(lz) >= exp_q) begin
      zero_d = 1'b1;
    end else begin
      norm_d = sum_q[EXT_W-1:0] << lz;
      nexp_d = exp_q - EW'(lz);
    end
  end

  // RND: round-to-nearest-even, renormalise on carry, saturate to infinity
  always_comb begin
    rnd_res = '0;
    r_man   = norm_q[EXT_W-1:3];
    r_up    = norm_q[2] & (norm_q[1] | norm_q[0] | r_man[0]);
    r_sum   = {1'b0, r_man} + (MAN_W+1)'(r_up);
    r_exp   = nexp_q;
    r_frac  = r_sum[M_W-1:0];
    if (r_sum[MAN_W]) begin
      r_exp  = nexp_q + EW'(1);
      r_frac = r_sum[M_W:1];
    end
    if (spec_q)                      rnd_res = spec_res_q;
    else if (zero_q)                 rnd_res = '0;
    else if (r_exp >= EW'(EXP_MAX))  rnd_res = {sign_q, EXP_MAX, {M_W{1'b0}}};
    else                             rnd_res = {sign_q, r_exp[EXP_W-1:0], r_frac};
  end

  // Datapath pipeline registers, loaded only in their own stage
  always_ff @(posedge clk) begin
    case (state_q)
      S_ALIGN: begin
        sign_q     <= sign_d;
        exp_q      <= exp_d;
        big_q      <= big_d;
        small_q    <= small_d;
        sub_q      <= sub_d;
        spec_q     <= spec_d;
        spec_res_q <= spec_res_d;
      end
      S_ADD: sum_q <= sum_d;
      S_NORM: begin
        norm_q <= norm_d;
        nexp_q <= nexp_d;
        zero_q <= zero_d;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/fp_acc.md
FP_ACC -- requirements
Module: fp_acc

Interface
REQ-001 SHALL have parameter BIT_W, default 32, FP32 word width.
REQ-002 SHALL have parameter EXP_W, default 8, exponent width.
REQ-003 SHALL have parameter M_W, default 23, stored mantissa width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  product beat from fmul stage is valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-008 SHALL have port in_data  input  BIT_W  FP32 product to accumulate.
REQ-009 SHALL have port in_last  input  1  beat closes the current sum.
REQ-010 SHALL have port out_valid  output  1  out_data/out_count hold a finished sum.
REQ-011 SHALL have port out_ready  input  1  consumer takes the sum.
REQ-012 SHALL have port out_data  output  BIT_W  FP32 accumulated sum.
REQ-013 SHALL have port out_count  output  16  number of beats in the sum, saturating at 65535.

Function
REQ-014 SHALL transfer a beat only on a rising edge where in_valid && in_ready.
REQ-015 SHALL implement states IDLE, ALIGN, ADD, NORM, RND, OUT.
REQ-016 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in OUT.
REQ-017 SHALL move IDLE->ALIGN on accept, then ALIGN->ADD->NORM->RND, one state per cycle.
REQ-018 SHALL write the rounded result into the accumulator at the end of RND, then go RND->OUT if the beat had in_last, else RND->IDLE.
REQ-019 SHALL therefore reassert in_ready (non-last) or assert out_valid (last) exactly 5 cycles after the accept edge, giving 1 beat per 5 cycles.
REQ-020 In OUT SHALL hold out_data/out_count stable until out_valid && out_ready, then go to IDLE with accumulator=+0 and count=0.
REQ-021 SHALL start every sum from accumulator +0 (00000000).
REQ-022 ALIGN: SHALL shift the smaller-magnitude mantissa right by the exponent difference, keeping guard, round and sticky bits; a shift >= 26 leaves only sticky.
REQ-023 ADD: SHALL add or subtract the aligned 24-bit mantissas by sign, with result sign taken from the larger magnitude.
REQ-024 NORM: SHALL renormalise by a one-bit right shift on carry or a leading-zero left shift on cancellation, adjusting the exponent.
REQ-025 RND: SHALL apply round-to-nearest-even, renormalising on mantissa carry-out.
REQ-026 SHALL flush subnormal inputs (exp=0) to signed zero, and flush subnormal results to +0.
REQ-027 SHALL return exact cancellation (x + -x) as +0.
REQ-028 SHALL return signed infinity (7F800000 / FF800000) when the result exponent reaches 255.
REQ-029 SHALL return 7FC00000 for NaN input, for inf + -inf, or once the accumulator is NaN, until the sum is emitted.
REQ-030 Inf plus finite SHALL remain that inf.
REQ-031 SHALL count accepted beats including the last, saturating at 65535, and report the count on out_count.

Reset
REQ-032 When rst_n=0 at a rising edge, SHALL enter IDLE with accumulator=+0, count=0, out_valid=0, out_data=0, out_count=0 and in_ready=1 on the next cycle.
REQ-033 Reset mid-operation (any of ALIGN..OUT) SHALL discard the partial sum and pending output with no further out_valid.

Verification
REQ-034 Beats 3F800000 then 40000000 (last) -> out_data=40400000, out_count=2, out_valid 5 cycles after the last accept.
REQ-035 Beats 3F800000, BF800000 (last) -> 00000000; beats 7F7FFFFF, 7F7FFFFF (last) -> 7F800000; beats 7F800000, FF800000 (last) -> 7FC00000.
REQ-036 Beats 3F800000, 33800000 (last) -> 3F800000 (tie to even); beats 3F800001, 33800000 (last) -> 3F800002; single beat 00000001 (last) -> 00000000.
REQ-037 Backpressure: out_ready=0 for 3 cycles in OUT -> out_data/out_count stable and in_ready=0; in_valid held with no beat lost or duplicated.
REQ-038 Mid-operation reset: rst_n=0 in ADD -> next cycle in_ready=1, out_valid=0; a following single beat 40000000 (last) -> 40000000, out_count=1.
